wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface: consumes the latched MEM/WB signals (RegWrite, MemtoReg, ALU data, memory read data, destination address).
- Selects the write-back value, commits it into a 32-entry architectural register file, and serves two ID-stage read ports.
- Read ports have same-cycle write-through bypass, so ID never sees stale data from an instruction retiring in WB.
- Keeps a retired-write counter for CPI/debug visibility.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- CNT_W, 32, width of the retired-write counter

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- start_i  input  1  asynchronous active-low reset
- RegWrite_i  input  1  write enable from MEM/WB
- MemtoReg_i  input  1  1 = write ReadData_i, 0 = write ALUdata_i
- ALUdata_i  input  DATA_W  ALU result from MEM/WB
- ReadData_i  input  DATA_W  data-memory read value from MEM/WB
- RegWaddr_i  input  ADDR_W  destination register
- RS1addr_i  input  ADDR_W  read port 1 address (ID stage)
- RS2addr_i  input  ADDR_W  read port 2 address (ID stage)
- RS1data_o  output  DATA_W  read port 1 data
- RS2data_o  output  DATA_W  read port 2 data
- WBdata_o  output  DATA_W  selected write-back value; also drives the EX forwarding path
- WrCount_o  output  CNT_W  number of committed non-x0 writes since reset

Behaviour:
- Reset:
  - start_i low asynchronously clears all 2**ADDR_W entries to 0 and WrCount_o to 0.
  - While start_i is low, writes and counter increments are suppressed.
  - Reads stay combinational during reset and return 0.
  - Release is synchronous in effect: the first commit happens on the first rising edge with start_i high.
- Write-back mux (combinational):
  - WBdata_o = MemtoReg_i ? ReadData_i : ALUdata_i.
  - Valid regardless of RegWrite_i.
- Commit:
  - Condition: rising edge with start_i high, RegWrite_i=1 and RegWaddr_i != 0.
  - Action: entry[RegWaddr_i] <= WBdata_o.
  - Write latency is 1 edge.
- Register x0:
  - Always reads 0.
  - Never written.
  - A write to x0 is a no-op and does not count.
- Read ports (combinational):
  - For each port p in {1,2}: if RSp_addr == 0, then 0.
  - Else if RegWrite_i=1 and start_i=1 and RegWaddr_i == RSp_addr, then WBdata_o (bypass).
  - Else entry[RSp_addr].
  - Bypass makes the register file behave as write-before-read within one cycle.
- Both ports may address the same register; both return identical data, with bypass applied to each independently.
- Counter:
  - WrCount_o increments by 1 on every commit.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
  - Reset mid-operation clears it immediately.
- Simultaneous events: no inter-port conflicts exist; only one write port.
- Timing: no hold or stall input. MEM/WB presents a new value every cycle and each is consumed on that edge.
- Unknowns: X on RegWrite_i is not supported. Benches drive only 0 or 1.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W, ADDR_W, REG_ZERO = 0.
  - WB select encoding: WB_ALU = 0, WB_MEM = 1.
- One sub-module, wb_regfile_bypass_rd: the single read port (x0 and bypass logic).
- It is instantiated twice.
- The storage array, write-back mux and counter live in the top.

Test Plan:
1. Reset then read: start_i low; then RS1addr=5, RS2addr=31 -> RS1data_o=0, RS2data_o=0, WrCount_o=0.
2. ALU write-back: RegWrite=1, MemtoReg=0, ALUdata=0x0000_00AA, Waddr=3, one edge; then RegWrite=0, RS1addr=3 -> RS1data_o=0xAA, WrCount_o=1.
3. Load write-back and bypass:
   - Drive RegWrite=1, MemtoReg=1, ReadData=0xDEAD_BEEF, ALUdata=0x1234, Waddr=7, with RS1addr=RS2addr=7 before the edge.
   - Before the edge: both outputs = 0xDEADBEEF.
   - After the edge with RegWrite=0: both outputs still = 0xDEADBEEF.
4. x0 protection: RegWrite=1, Waddr=0, ALUdata=0xFFFF_FFFF, 3 edges -> RS1addr=0 reads 0 at every cycle, WrCount_o unchanged.
5. Reset mid-operation:
   - Write x9=0x55 and confirm.
   - Pulse start_i low between edges -> RS1addr=9 reads 0 immediately and WrCount_o=0 without a clock edge.
   - A subsequent write works normally.
6. Counter wrap: with CNT_W=4, perform 17 commits to x1..x17 (address wraps mod 32, skipping x0) -> WrCount_o=1; RegWrite=0 cycles do not increment.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and write-back select encoding for the MEM/WB write-back slice.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;
endpackage

// File: rtl/wb_regfile_bypass_rd.sv
// One ID-stage read port: x0 forced to zero, retiring write forwarded ahead of storage.
module wb_regfile_bypass_rd #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] entry,
  input  logic              wr_live,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data
);
  import cpu_pkg::*;

  always_comb begin
    rs_data = entry;
    if (rs_addr == ADDR_W'(REG_ZERO)) begin
      rs_data = '0;
    end else if (wr_live && (wr_addr == rs_addr)) begin
      rs_data = wb_data;
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, commits it into the 32-entry register file,
// serves two bypassed read ports and counts retired non-x0 writes.
module wb_regfile #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [ADDR_W-1:0] RegWaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic [CNT_W-1:0]  WrCount_o
);
  import cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  wb_sel_e           wb_sel;
  logic              wr_live;
  logic              commit;

  assign wb_sel   = wb_sel_e'(MemtoReg_i);
  assign WBdata_o = (wb_sel == WB_MEM) ? ReadData_i : ALUdata_i;

  // Bypass is gated by start_i so reads return 0 for the whole reset window.
  assign wr_live = RegWrite_i & start_i;
  assign commit  = RegWrite_i && (RegWaddr_i != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      WrCount_o <= '0;
    end else if (commit) begin
      regs[RegWaddr_i] <= WBdata_o;
      WrCount_o        <= WrCount_o + CNT_W'(1);
    end
  end

  wb_regfile_bypass_rd #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .rs_addr (RS1addr_i),
    .entry   (regs[RS1addr_i]),
    .wr_live (wr_live),
    .wr_addr (RegWaddr_i),
    .wb_data (WBdata_o),
    .rs_data (RS1data_o)
  );

  wb_regfile_bypass_rd #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd2 (
    .rs_addr (RS2addr_i),
    .entry   (regs[RS2addr_i]),
    .wr_live (wr_live),
    .wr_addr (RegWaddr_i),
    .wb_data (WBdata_o),
    .rs_data (RS2data_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expectations from a write-before-read model,
// a negedge monitor pops and compares against the DUT outputs.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          start_i = 1'b0;
  logic          RegWrite_i = 1'b0;
  logic          MemtoReg_i = 1'b0;
  logic [DW-1:0] ALUdata_i = '0;
  logic [DW-1:0] ReadData_i = '0;
  logic [AW-1:0] RegWaddr_i = '0;
  logic [AW-1:0] RS1addr_i = '0;
  logic [AW-1:0] RS2addr_i = '0;
  logic [DW-1:0] RS1data_o;
  logic [DW-1:0] RS2data_o;
  logic [DW-1:0] WBdata_o;
  logic [CW-1:0] WrCount_o;

  always #5 clk_i = ~clk_i;

  wb_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk_i      (clk_i),
    .start_i    (start_i),
    .RegWrite_i (RegWrite_i),
    .MemtoReg_i (MemtoReg_i),
    .ALUdata_i  (ALUdata_i),
    .ReadData_i (ReadData_i),
    .RegWaddr_i (RegWaddr_i),
    .RS1addr_i  (RS1addr_i),
    .RS2addr_i  (RS2addr_i),
    .RS1data_o  (RS1data_o),
    .RS2data_o  (RS2data_o),
    .WBdata_o   (WBdata_o),
    .WrCount_o  (WrCount_o)
  );

  typedef struct {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] wb;
    logic [CW-1:0] cnt;
    int            tag;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl [32];
  int unsigned   mcnt = 0;
  int            vectors = 0;
  int            miscompares = 0;

  // Model: the architectural file as seen after this cycle's write lands (write-before-read).
  task automatic push_expect(input bit live);
    logic [DW-1:0] view [32];
    logic [DW-1:0] wb;
    exp_t          e;
    wb = MemtoReg_i ? ReadData_i : ALUdata_i;
    view = mdl;
    if (live && RegWrite_i && RegWaddr_i != 5'd0) view[RegWaddr_i] = wb;
    view[0] = '0;
    e.rs1 = view[RS1addr_i];
    e.rs2 = view[RS2addr_i];
    e.wb  = wb;
    e.cnt = CW'(mcnt);
    e.tag = 0;
    sb.push_back(e);
    if (live && RegWrite_i && RegWaddr_i != 5'd0) begin
      mdl[RegWaddr_i] = wb;
      mcnt = (mcnt + 1) % (1 << CW);
    end
  endtask

  task automatic tag_last(input int tag);
    exp_t e;
    e = sb.pop_back();
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic apply(input logic rw, input logic ms, input logic [DW-1:0] alu,
                       input logic [DW-1:0] rd, input logic [AW-1:0] wa,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2, input int tag);
    @(posedge clk_i);
    #1;
    RegWrite_i = rw;
    MemtoReg_i = ms;
    ALUdata_i  = alu;
    ReadData_i = rd;
    RegWaddr_i = wa;
    RS1addr_i  = r1;
    RS2addr_i  = r2;
    push_expect(1'b1);
    tag_last(tag);
  endtask

  // Holds start_i low across n-1 rising edges with a live write request, then releases mid-cycle.
  task automatic reset_pulse(input int n, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                             input int tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
      start_i    = 1'b0;
      RegWrite_i = 1'b1;
      MemtoReg_i = 1'($urandom_range(0, 1));
      ALUdata_i  = $urandom;
      ReadData_i = $urandom;
      RegWaddr_i = (r1 == 5'd0) ? 5'd1 : r1;
      RS1addr_i  = r1;
      RS2addr_i  = r2;
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mcnt = 0;
      push_expect(1'b0);
      tag_last(tag);
    end
    @(negedge clk_i);
    #1;
    RegWrite_i = 1'b0;
    start_i    = 1'b1;
  endtask

  task automatic chk(input string nm, input int tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s tag=%0d got=%h want=%h t=%0t", nm, tag, got, want, $time);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++;
      chk("rs1", e.tag, RS1data_o, e.rs1);
      chk("rs2", e.tag, RS2data_o, e.rs2);
      chk("wbdata", e.tag, WBdata_o, e.wb);
      chk("wrcount", e.tag, DW'(WrCount_o), DW'(e.cnt));
    end
  end

  initial begin
    logic [AW-1:0] wa;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    // 1: reset then read
    reset_pulse(2, 5'd5, 5'd31, 1);
    // 2: ALU write-back
    apply(1'b1, 1'b0, 32'h0000_00AA, 32'h0000_0055, 5'd3, 5'd0, 5'd3, 2);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0, 2);
    // 3: load write-back with same-cycle bypass on both ports
    apply(1'b1, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7, 3);
    apply(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 5'd7, 5'd7, 3);
    // 4: x0 protection
    repeat (3) apply(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 4);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 4);
    // 5: reset mid-operation
    apply(1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd9, 5'd0, 5'd0, 5);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7, 5);
    reset_pulse(1, 5'd9, 5'd7, 5);
    apply(1'b1, 1'b1, 32'h0, 32'h0000_0066, 5'd9, 5'd0, 5'd0, 5);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9, 5);
    // 6: counter wrap over 17 commits, idle cycles interleaved
    reset_pulse(1, 5'd1, 5'd2, 6);
    for (int i = 1; i <= 17; i++) begin
      apply(1'b1, 1'b0, $urandom, $urandom, AW'(i % 32), AW'(i), AW'(i - 1), 6);
      if (i % 4 == 0) apply(1'b0, 1'b0, $urandom, $urandom, AW'(i), AW'(i), 5'd0, 6);
    end
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd1, 6);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse(int'($urandom_range(1, 2)), AW'($urandom_range(0, 31)),
                    AW'($urandom_range(0, 31)), 100);
      end else begin
        wa = AW'($urandom_range(0, 31));
        r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
        r2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
        apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              wa, r1, r2, 100);
      end
    end

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk_i);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
